// File: rtl/jt8255_periph.sv
// Device-side mode 1 handshake engine for jt8255: strobes bytes into port A
// (STBA/IBFA) and drains bytes written to port B (OBFB/ACKB) into a stream sink.
module jt8255_periph #(
  parameter int STB_W  = 2,
  parameter int ACK_W  = 2,
  parameter int IBF_TO = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] pa_dout,
  input  logic [7:0] pb_din,
  input  logic [7:0] pc_din,
  output logic [7:0] pc_dout,
  output logic [1:0] dbg_tx_state,
  output logic [1:0] dbg_rx_state
);

  typedef enum logic [1:0] {
    TX_IDLE     = 2'd0,
    TX_STROBE   = 2'd1,
    TX_WAIT_IBF = 2'd2,
    TX_WAIT_RD  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE     = 2'd0,
    RX_ACK      = 2'd1,
    RX_WAIT_OBF = 2'd2
  } rx_state_t;

  localparam logic [3:0] STB_LAST = 4'(STB_W);
  localparam logic [3:0] ACK_LAST = 4'(ACK_W);
  localparam logic [7:0] TO_LAST  = 8'(IBF_TO - 1);

  tx_state_t  r_tx_state;
  rx_state_t  r_rx_state;
  logic [7:0] r_pa_dout;
  logic       r_stba;
  logic [3:0] r_stb_cnt;
  logic [7:0] r_to_cnt;
  logic       r_tx_err;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_ackb;
  logic [3:0] r_ack_cnt;

  logic w_ibfa;
  logic w_obfb_n;
  logic w_tx_fire;
  logic w_rx_free;
  logic w_rx_cap;
  logic w_unused;

  assign w_ibfa   = pc_din[5];
  assign w_obfb_n = pc_din[1];
  assign w_unused = &{1'b0, pc_din[7:6], pc_din[4:2], pc_din[0]};

  // Both streams: a beat transfers on the edge where valid & ready are high;
  // valid/data hold until then and never depend on ready.
  assign tx_ready  = (r_tx_state == TX_IDLE) && en;
  assign w_tx_fire = tx_valid && tx_ready;
  assign w_rx_free = !r_rx_valid || rx_ready;
  assign w_rx_cap  = (r_rx_state == RX_IDLE) && en && !w_obfb_n && w_rx_free;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx_state <= TX_IDLE;
      r_pa_dout  <= 8'hFF;
      r_stba     <= 1'b1;
      r_stb_cnt  <= 4'd0;
      r_to_cnt   <= 8'd0;
      r_tx_err   <= 1'b0;
    end else begin
      r_tx_err <= 1'b0;
      case (r_tx_state)
        TX_IDLE: begin
          if (w_tx_fire) begin
            r_pa_dout  <= tx_data;
            r_stba     <= 1'b0;
            r_stb_cnt  <= 4'd1;
            r_tx_state <= TX_STROBE;
          end
        end
        TX_STROBE: begin
          if (r_stb_cnt >= STB_LAST) begin
            r_stba     <= 1'b1;
            r_to_cnt   <= 8'd0;
            r_tx_state <= TX_WAIT_IBF;
          end else begin
            r_stb_cnt <= r_stb_cnt + 4'd1;
          end
        end
        TX_WAIT_IBF: begin
          // IBFA arriving on the last allowed cycle still counts as success.
          if (w_ibfa) begin
            r_tx_state <= TX_WAIT_RD;
          end else if (r_to_cnt >= TO_LAST) begin
            r_tx_err   <= 1'b1;
            r_tx_state <= TX_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
          end
        end
        TX_WAIT_RD: begin
          if (!w_ibfa) r_tx_state <= TX_IDLE;
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rx_state <= RX_IDLE;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_ackb     <= 1'b1;
      r_ack_cnt  <= 4'd0;
    end else begin
      // A capture in the same cycle as a consume keeps valid high with new data.
      if (w_rx_cap) begin
        r_rx_data  <= pb_din;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_cap) begin
            r_ackb     <= 1'b0;
            r_ack_cnt  <= 4'd1;
            r_rx_state <= RX_ACK;
          end
        end
        RX_ACK: begin
          if (r_ack_cnt >= ACK_LAST) begin
            r_ackb     <= 1'b1;
            r_rx_state <= RX_WAIT_OBF;
          end else begin
            r_ack_cnt <= r_ack_cnt + 4'd1;
          end
        end
        RX_WAIT_OBF: begin
          if (w_obfb_n) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign tx_err       = r_tx_err;
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign pa_dout      = r_pa_dout;
  assign pc_dout      = {3'b111, r_stba, 1'b1, r_ackb, 2'b11};
  assign dbg_tx_state = r_tx_state;
  assign dbg_rx_state = r_rx_state;

endmodule

// File: tb/tb_jt8255_periph.sv
// Bench for jt8255_periph: a behavioural jt8255 pin model plus a scoreboard
// that checks strobed/received bytes, pulse widths and timeout timing.
module tb_jt8255_periph;

  localparam int STB_W  = 2;
  localparam int ACK_W  = 2;
  localparam int IBF_TO = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] pa_dout;
  logic [7:0] pb_din;
  logic [7:0] pc_din;
  logic [7:0] pc_dout;
  logic [1:0] dbg_tx_state;
  logic [1:0] dbg_rx_state;

  // jt8255 pin model state
  logic       ibfa = 1'b0;
  logic       obf_n = 1'b1;
  logic       tie_ibf0 = 1'b0;
  logic [7:0] pb_val = 8'h00;
  logic [7:0] pa_latch = 8'h00;
  logic       stba_prev = 1'b1;
  logic       ackb_prev = 1'b1;
  int         stb_len = 0;
  int         ack_len = 0;
  int         rd_wait = 0;
  int         rise_cyc = 0;
  int         cyc = 0;
  int         err_pulses = 0;

  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];
  int         exp_err_q[$];

  int n_chk = 0;
  int n_err = 0;

  assign pb_din = pb_val;
  assign pc_din = {2'b11, ibfa & ~tie_ibf0, 3'b111, obf_n, 1'b1};

  jt8255_periph #(.STB_W(STB_W), .ACK_W(ACK_W), .IBF_TO(IBF_TO)) dut (
    .clk(clk), .rstn(rstn), .en(en),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_err(tx_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .pa_dout(pa_dout), .pb_din(pb_din), .pc_din(pc_din), .pc_dout(pc_dout),
    .dbg_tx_state(dbg_tx_state), .dbg_rx_state(dbg_rx_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // pin model and monitor: sampled on the falling edge
  always @(negedge clk) begin
    if (!rstn) begin
      ibfa = 1'b0; obf_n = 1'b1; stba_prev = 1'b1; ackb_prev = 1'b1;
      stb_len = 0; ack_len = 0; rd_wait = 0;
    end else begin
      if (!pc_dout[4]) stb_len++;
      if (pc_dout[4] && !stba_prev) begin
        check("stba_width", stb_len, STB_W);
        stb_len  = 0;
        pa_latch = pa_dout;
        rise_cyc = cyc;
        rd_wait  = 0;
        if (!tie_ibf0) ibfa = 1'b1;
      end else if (ibfa) begin
        rd_wait++;
        check("pa_stable", pa_dout, pa_latch);
        if (rd_wait == 3) begin
          if (exp_tx_q.size() == 0) check("tx_unexpected", pa_latch, 0);
          else check("tx_byte", pa_latch, exp_tx_q.pop_front());
          ibfa = 1'b0;
        end
      end
      stba_prev = pc_dout[4];

      if (!pc_dout[2]) ack_len++;
      if (pc_dout[2] && !ackb_prev) begin
        check("ackb_width", ack_len, ACK_W);
        ack_len = 0;
        obf_n   = 1'b1;
      end
      ackb_prev = pc_dout[2];

      if (rx_valid && rx_ready) begin
        if (exp_rx_q.size() == 0) check("rx_unexpected", rx_data, 0);
        else check("rx_byte", rx_data, exp_rx_q.pop_front());
      end

      if (tx_err) begin
        err_pulses++;
        if (exp_err_q.size() == 0) check("tx_err_unexpected", 1, 0);
        else check("tx_err_delay", cyc - rise_cyc, exp_err_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic send_tx(input logic [7:0] d);
    bit ok = 0;
    @(posedge clk); #1;
    tx_data = d; tx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_ready) begin ok = 1; break; end
    end
    check("tx_accept", ok, 1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic cpu_write_b(input logic [7:0] d);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (obf_n) begin ok = 1; break; end
    end
    check("obf_free", ok, 1);
    @(posedge clk); #1;
    pb_val = d; obf_n = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (dbg_tx_state == 2'd0 && dbg_rx_state == 2'd0 && exp_tx_q.size() == 0 &&
          exp_rx_q.size() == 0 && exp_err_q.size() == 0 && !ibfa && obf_n) begin
        ok = 1; break;
      end
    end
    check(name, ok, 1);
  endtask

  initial begin
    // reset values, en=1 so tx_ready reads 1 during reset
    repeat (2) @(negedge clk);
    check("rst_pa_dout", pa_dout, 8'hFF);
    check("rst_pc_dout", pc_dout, 8'hFF);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_err", tx_err, 0);
    check("rst_tx_ready", tx_ready, 1);
    @(posedge clk); #1 rstn = 1'b1;

    // TX single byte
    exp_tx_q.push_back(8'hA5);
    send_tx(8'hA5);
    wait_done("tx_single_done");
    check("tx_ready_back", tx_ready, 1);

    // RX single byte
    rx_ready = 1'b1;
    exp_rx_q.push_back(8'h3C);
    cpu_write_b(8'h3C);
    wait_done("rx_single_done");

    // RX back-pressure
    rx_ready = 1'b0;
    exp_rx_q.push_back(8'h11);
    exp_rx_q.push_back(8'h22);
    cpu_write_b(8'h11);
    cpu_write_b(8'h22);
    repeat (10) @(negedge clk);
    check("bp_ackb_high", pc_dout[2], 1);
    check("bp_obf_low", obf_n, 0);
    check("bp_rx_data", rx_data, 8'h11);
    check("bp_rx_idle", dbg_rx_state, 0);
    @(posedge clk); #1 rx_ready = 1'b1;
    wait_done("bp_done");

    // IBF timeout
    tie_ibf0 = 1'b1;
    exp_err_q.push_back(IBF_TO);
    send_tx(8'h77);
    wait_done("timeout_done");
    check("timeout_pulses", err_pulses, 1);
    check("timeout_pa_dout", pa_dout, 8'h77);
    tie_ibf0 = 1'b0;

    // en dropped during STROBE: in-flight byte completes, next byte waits
    exp_tx_q.push_back(8'h5A);
    send_tx(8'h5A);
    check("en_in_strobe", dbg_tx_state, 1);
    en = 1'b0; tx_data = 8'hC3; tx_valid = 1'b1;
    wait_done("en_inflight_done");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("en_blocked_ready", tx_ready, 0);
      check("en_blocked_stba", pc_dout[4], 1);
    end
    exp_tx_q.push_back(8'hC3);
    @(posedge clk); #1 en = 1'b1;
    @(posedge clk); #1 tx_valid = 1'b0;
    wait_done("en_resume_done");

    // reset asserted during ACK drops the captured byte
    rx_ready = 1'b0;
    cpu_write_b(8'h99);
    begin
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (!pc_dout[2]) begin ok = 1; break; end
      end
      check("ack_seen", ok, 1);
    end
    #1 rstn = 1'b0;
    @(negedge clk);
    check("rst_ack_pc_dout", pc_dout, 8'hFF);
    check("rst_ack_rx_valid", rx_valid, 0);
    check("rst_ack_rx_state", dbg_rx_state, 0);
    @(posedge clk); #1 rstn = 1'b1; rx_ready = 1'b1;

    // concurrent TX and RX
    exp_tx_q.push_back(8'h01);
    exp_rx_q.push_back(8'hFE);
    fork
      send_tx(8'h01);
      cpu_write_b(8'hFE);
    join
    wait_done("concurrent_done");

    check("final_tx_q", exp_tx_q.size(), 0);
    check("final_rx_q", exp_rx_q.size(), 0);
    check("final_err_pulses", err_pulses, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/jt8255_periph.md
# jt8255_periph

Peripheral-side handshake engine that sits directly downstream of jt8255 on its port pins and implements the device end of the mode 1 strobed protocol. Port A (mode 1 input): it presents bytes from a valid/ready source and strobes them in with STBA. Port B (mode 1 output): it captures the bytes the CPU wrote, acknowledges them with ACKB and hands them to a valid/ready sink. It connects pin-to-pin to jt8255 on the same clock; no synchronisers.

## Interface
Parameters:
- STB_W, 2: STBA low pulse width in clk cycles (1..15).
- ACK_W, 2: ACKB low pulse width in clk cycles (1..15).
- IBF_TO, 8: cycles to wait for IBFA to rise after STBA before flagging an error (1..255).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, same as jt8255.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  enables starting new transactions.
- tx_data  in  8  byte to send to the CPU via port A.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  high in TX IDLE with en=1; the byte is accepted on tx_valid & tx_ready.
- tx_err  out  1  one-cycle pulse on IBFA timeout.
- rx_data  out  8  byte received from the CPU via port B.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  sink accepts; clears rx_valid on rx_valid & rx_ready.
- pa_dout  out  8  drives jt8255 porta_din.
- pb_din  in  8  from jt8255 portb_dout.
- pc_din  in  8  from jt8255 portc_dout. Bit 5 = IBFA; bit 1 = OBFB, active-low.
- pc_dout  out  8  drives jt8255 portc_din. Bit 4 = STBA, bit 2 = ACKB; all other bits are constant 1.

## Operation
TX FSM (port A): IDLE -> STROBE -> WAIT_IBF -> WAIT_RD -> IDLE.
- IDLE: on tx_valid & tx_ready, latch tx_data into pa_dout and go to STROBE.
- STROBE: hold STBA low for exactly STB_W cycles, then drive it high. The rising edge is what jt8255 samples. Go to WAIT_IBF.
- WAIT_IBF: wait for pc_din[5]=1, then go to WAIT_RD. A counter from 0 times out at IBF_TO cycles: pulse tx_err, return to IDLE.
- WAIT_RD: hold pa_dout until pc_din[5]=0 (CPU read of port A), then go to IDLE.
- pa_dout is stable from latch until leaving WAIT_RD. It keeps its last value while in IDLE.

RX FSM (port B): IDLE -> ACK -> WAIT_OBF -> IDLE.
- IDLE: if en=1, pc_din[1]=0 and (rx_valid=0, or rx_valid & rx_ready in the same cycle), capture pb_din into rx_data, set rx_valid, go to ACK.
- IDLE back-pressure: if the buffer is full, stay in IDLE and leave ACKB high. OBFB stays low, which throttles the CPU.
- ACK: hold ACKB low for ACK_W cycles, then drive it high and go to WAIT_OBF.
- WAIT_OBF: wait for pc_din[1]=1, then go to IDLE. This prevents a second capture of the same byte.
- rx_valid clears on rx_valid & rx_ready unless a new capture happens in the same cycle. A new capture wins: rx_valid stays 1 with the new data.

General rules:
- en=0 blocks only the IDLE transitions. A transaction already in flight always completes.
- The TX and RX FSMs are fully independent. Simultaneous activity on both is legal.
- Pulse counters are 4 bits and the timeout counter is 8 bits. Counters saturate and never wrap.

## Timing
- Reset values: pa_dout=8'hFF, pc_dout=8'hFF (STBA and ACKB high), rx_data=8'h00, rx_valid=0, tx_err=0. Both FSMs are in IDLE.
- tx_ready is combinational from state and en, so it reads 1 during reset when en=1.
- All outputs except tx_ready are registered.
- TX: tx_valid & tx_ready sampled at edge N -> pa_dout updated and STBA low from N+1 through N+STB_W, high at N+STB_W+1.
- RX: OBFB low sampled at edge N with buffer free -> rx_valid=1 and ACKB low from N+1 through N+ACK_W, high at N+ACK_W+1.
- tx_err is high for exactly one cycle, the cycle after the IBF_TO-th wait cycle.
- Reset asserted mid-transaction returns everything to the reset values immediately, including STBA/ACKB high. Any buffered byte is dropped.

## Test plan
- TX single byte: STB_W=2, send 8'hA5 with jt8255 in mode 1 A-input and CPU reading port A -> STBA low for exactly 2 cycles; IBFA rises; CPU reads 8'hA5; IBFA falls; tx_ready returns to 1.
- RX single byte: CPU writes 8'h3C to port B in mode 1 output -> OBFB low; rx_data=8'h3C with rx_valid=1; ACKB low for 2 cycles; OBFB returns high.
- RX back-pressure: hold rx_ready=0, CPU writes 8'h11 then 8'h22 -> only 8'h11 captured; ACKB for the second byte is withheld until rx_ready=1, then 8'h22 is delivered.
- IBF timeout: tie pc_din[5]=0, send 8'h77 -> tx_err pulses once, IBF_TO cycles after STBA rises; TX FSM returns to IDLE.
- en and reset: drop en during STROBE -> the transaction completes and no new byte is accepted. Assert rstn low during ACK -> pc_dout=8'hFF and rx_valid=0 on the next sample.
- Concurrent TX and RX: a TX of 8'h01 and an RX of 8'hFE in overlapping cycles -> both complete with correct data; STBA and ACKB pulses are independent.
